vedic_mult_pipe: RTL

- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready stream interface.
- Generalises the fixed 16-bit combinational Vedic multiplier.
  - Operand width is a parameter.
  - Per-transaction signed or unsigned mode.
  - Three-stage register pipeline with full backpressure.
- Sits between the operand sequencer and the result sink in the 32-bit multiplier datapath.
- The top level instantiates it with WIDTH=32.

---
 rtl/vedic_mult_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: S1 magnitudes/sign, S2 four half-width Vedic partial products, S3 recombine and negate.
// Optional accumulator output enabled by defining VEDIC_MULT_ACC_EN.

module vedic_nxn #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  generate
    if (N == 2) begin : g_cell
      logic cross_c;
      assign p[0]    = a[0] & b[0];
      assign p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
      assign cross_c = (a[1] & b[0]) & (a[0] & b[1]);
      assign p[2]    = (a[1] & b[1]) ^ cross_c;
      assign p[3]    = (a[1] & b[1]) & cross_c;
    end else begin : g_split
      localparam int H = N / 2;
      logic [N-1:0] q [4];
      // q[0]=aL*bL, q[1]=aH*bL, q[2]=aL*bH, q[3]=aH*bH
      for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        localparam int SA = (gi % 2) * H;
        localparam int SB = (gi / 2) * H;
        vedic_nxn #(.N(H)) u_sub (
          .a(a[SA +: H]),
          .b(b[SB +: H]),
          .p(q[gi])
        );
      end
      assign p = {{N{1'b0}}, q[0]} + ({{N{1'b0}}, q[1]} << H)
               + ({{N{1'b0}}, q[2]} << H) + {q[3], {N{1'b0}}};
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
`ifdef VEDIC_MULT_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [2*WIDTH+7:0] out_acc
`endif
);
  localparam int H = WIDTH / 2;

  logic adv;

  logic               v1_reg, v2_reg, v3_reg;
  logic [WIDTH-1:0]   mag_a_reg, mag_b_reg;
  logic               neg1_reg, neg2_reg;
  logic [TAG_W-1:0]   tag1_reg, tag2_reg, tag3_reg;
  logic [WIDTH-1:0]   pp_reg [4];
  logic [2*WIDTH-1:0] p3_reg;

  logic [WIDTH-1:0]   mag_a_next, mag_b_next;
  logic               neg1_next;
  logic [WIDTH-1:0]   pp_next [4];
  logic [2*WIDTH-1:0] sum_next, prod_next;

  // Whole pipeline stalls only when the final stage holds an unaccepted result.
  assign adv      = !(v3_reg && !out_ready);
  assign in_ready = adv;

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  assign mag_a_next = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b_next = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign neg1_next  = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      localparam int SA = (gi % 2) * H;
      localparam int SB = (gi / 2) * H;
      vedic_nxn #(.N(H)) u_pp (
        .a(mag_a_reg[SA +: H]),
        .b(mag_b_reg[SB +: H]),
        .p(pp_next[gi])
      );
    end
  endgenerate

  assign sum_next = {{WIDTH{1'b0}}, pp_reg[0]} + ({{WIDTH{1'b0}}, pp_reg[1]} << H)
                  + ({{WIDTH{1'b0}}, pp_reg[2]} << H) + {pp_reg[3], {WIDTH{1'b0}}};
  assign prod_next = neg2_reg ? -sum_next : sum_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      mag_a_reg <= '0;
      mag_b_reg <= '0;
      neg1_reg  <= 1'b0;
      neg2_reg  <= 1'b0;
      tag1_reg  <= '0;
      tag2_reg  <= '0;
      tag3_reg  <= '0;
      p3_reg    <= '0;
      for (int i = 0; i < 4; i++) pp_reg[i] <= '0;
    end else if (adv) begin
      v1_reg    <= in_valid;
      mag_a_reg <= mag_a_next;
      mag_b_reg <= mag_b_next;
      neg1_reg  <= neg1_next;
      tag1_reg  <= in_tag;
      v2_reg    <= v1_reg;
      neg2_reg  <= neg1_reg;
      tag2_reg  <= tag1_reg;
      for (int i = 0; i < 4; i++) pp_reg[i] <= pp_next[i];
      v3_reg    <= v2_reg;
      tag3_reg  <= tag2_reg;
      p3_reg    <= prod_next;
    end
  end

  assign out_valid = v3_reg;
  assign out_p     = p3_reg;
  assign out_tag   = tag3_reg;

`ifdef VEDIC_MULT_ACC_EN
  logic               sgn1_reg, sgn2_reg, sgn3_reg;
  logic [2*WIDTH+7:0] acc_ext;

  assign acc_ext = sgn3_reg ? {{8{p3_reg[2*WIDTH-1]}}, p3_reg} : {8'b0, p3_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn1_reg <= 1'b0;
      sgn2_reg <= 1'b0;
      sgn3_reg <= 1'b0;
      out_acc  <= '0;
    end else begin
      if (adv) begin
        sgn1_reg <= in_signed;
        sgn2_reg <= sgn1_reg;
        sgn3_reg <= sgn2_reg;
      end
      if (v3_reg && out_ready)
        out_acc <= acc_clr ? acc_ext : out_acc + acc_ext;
      else if (acc_clr)
        out_acc <= '0;
    end
  end
`endif
endmodule
